// File: rtl/mvu_pkg.sv
// rtl/mvu_pkg.sv - shared constants and types for the MVU control/status register block
//
// Purpose: register offsets, CTRL/STATUS bit positions, the block ID constant
//          and the APB completer state encoding used by mvu_apb_csr and
//          apb_completer_fsm.
// Ports:   none (package).
package mvu_pkg;

   localparam int APB_ADDR_WIDTH = 12;

   // Byte offsets of the register map
   localparam int CSR_CTRL   = 'h00;
   localparam int CSR_STATUS = 'h04;
   localparam int CSR_CFG0   = 'h08;
   localparam int CSR_ID     = 'h3C;

   // CTRL bits
   localparam int CTRL_START_BIT  = 0;
   localparam int CTRL_IRQ_EN_BIT = 1;

   // STATUS bits
   localparam int STATUS_BUSY_BIT = 0;
   localparam int STATUS_DONE_BIT = 1;

   localparam logic [31:0] MVU_CSR_ID = 32'h4D56_5501;

   typedef enum logic {
      CSR_IDLE   = 1'b0,
      CSR_ACCESS = 1'b1
   } csr_state_t;

endpackage

// File: rtl/apb_completer_fsm.sv
// rtl/apb_completer_fsm.sv - APB completer handshake with programmable wait states
//
// Purpose: tracks the IDLE/ACCESS handshake, latches the request in the setup
//          phase, counts WAIT_CYCLES wait states and pulses commit_o on the
//          edge where the transfer completes.
// Ports:   clk, rst                 - clock, synchronous active-high reset
//          psel/penable/pwrite      - APB control
//          paddr/pwdata/pstrb       - APB request
//          pready_o                 - registered ready (ACCESS with counter at 0)
//          commit_o                 - high in the cycle whose rising edge completes the transfer
//          req_*_o                  - request latched in the setup phase
module apb_completer_fsm
   import mvu_pkg::*;
#(
   parameter int ADDR_WIDTH  = APB_ADDR_WIDTH,
   parameter int DATA_WIDTH  = 32,
   parameter int WAIT_CYCLES = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    psel,
   input  logic                    penable,
   input  logic                    pwrite,
   input  logic [ADDR_WIDTH-1:0]   paddr,
   input  logic [DATA_WIDTH-1:0]   pwdata,
   input  logic [DATA_WIDTH/8-1:0] pstrb,
   output logic                    pready_o,
   output logic                    commit_o,
   output logic                    req_write_o,
   output logic [ADDR_WIDTH-1:0]   req_addr_o,
   output logic [DATA_WIDTH-1:0]   req_wdata_o,
   output logic [DATA_WIDTH/8-1:0] req_strb_o
);

   csr_state_t              state_q, state_d;
   logic [3:0]              cnt_q, cnt_d;
   logic                    write_q, write_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [DATA_WIDTH/8-1:0] strb_q, strb_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= CSR_IDLE;
         cnt_q   <= '0;
         write_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         strb_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         write_q <= write_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         strb_q  <= strb_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      write_d  = write_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      strb_d   = strb_q;
      commit_o = 1'b0;
      // Ready depends on registered state only, never on the live APB inputs
      pready_o = (state_q == CSR_ACCESS) && (cnt_q == 4'd0);

      case (state_q)
         CSR_IDLE: begin
            // penable without a preceding setup phase is ignored here
            if (psel && !penable) begin
               state_d = CSR_ACCESS;
               cnt_d   = 4'(WAIT_CYCLES);
               write_d = pwrite;
               addr_d  = paddr;
               wdata_d = pwdata;
               strb_d  = pstrb;
            end
         end
         CSR_ACCESS: begin
            if (!psel) begin
               state_d = CSR_IDLE;
            end else if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else if (penable) begin
               commit_o = 1'b1;
               state_d  = CSR_IDLE;
            end
         end
         default: state_d = CSR_IDLE;
      endcase
   end

   assign req_write_o = write_q;
   assign req_addr_o  = addr_q;
   assign req_wdata_o = wdata_q;
   assign req_strb_o  = strb_q;

endmodule

// File: rtl/mvu_apb_csr.sv
// rtl/mvu_apb_csr.sv - APB register block controlling one MVU job
//
// Purpose: decodes the latched APB request, holds CTRL/STATUS/CFG registers,
//          flags illegal accesses with pslverr and tracks job busy/done.
// Ports:   clk, rst                      - clock, synchronous active-high reset
//          psel/penable/pwrite/paddr/pwdata/pstrb - APB request
//          pready/prdata/pslverr         - APB response (registered-state only)
//          cfg_o                         - CFG words, word i at [32i+31:32i]
//          start_o                       - one-cycle job start pulse
//          done_i                        - one-cycle job completion pulse
//          irq_o                         - DONE & IRQ_EN
module mvu_apb_csr
   import mvu_pkg::*;
#(
   parameter int ADDR_WIDTH  = APB_ADDR_WIDTH,
   parameter int DATA_WIDTH  = 32,
   parameter int NUM_CFG     = 8,
   parameter int WAIT_CYCLES = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          psel,
   input  logic                          penable,
   input  logic                          pwrite,
   input  logic [ADDR_WIDTH-1:0]         paddr,
   input  logic [DATA_WIDTH-1:0]         pwdata,
   input  logic [DATA_WIDTH/8-1:0]       pstrb,
   output logic                          pready,
   output logic [DATA_WIDTH-1:0]         prdata,
   output logic                          pslverr,
   output logic [DATA_WIDTH*NUM_CFG-1:0] cfg_o,
   output logic                          start_o,
   input  logic                          done_i,
   output logic                          irq_o
);

   localparam logic [ADDR_WIDTH-1:0] A_CTRL   = ADDR_WIDTH'(CSR_CTRL);
   localparam logic [ADDR_WIDTH-1:0] A_STATUS = ADDR_WIDTH'(CSR_STATUS);
   localparam logic [ADDR_WIDTH-1:0] A_CFG0   = ADDR_WIDTH'(CSR_CFG0);
   localparam logic [ADDR_WIDTH-1:0] A_ID     = ADDR_WIDTH'(CSR_ID);

   logic                    rdy, commit, req_write;
   logic [ADDR_WIDTH-1:0]   req_addr;
   logic [DATA_WIDTH-1:0]   req_wdata;
   logic [DATA_WIDTH/8-1:0] req_strb;

   logic irq_en_q, irq_en_d, busy_q, busy_d, done_q, done_d, start_q, start_d;
   logic [DATA_WIDTH-1:0] cfg_q [NUM_CFG];
   logic [DATA_WIDTH-1:0] cfg_d [NUM_CFG];

   logic                  is_ctrl, is_status, is_id, aligned, start_req, err, wr_ok;
   logic [NUM_CFG-1:0]    cfg_hit;
   logic [DATA_WIDTH-1:0] rdata;

   apb_completer_fsm #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .WAIT_CYCLES(WAIT_CYCLES)
   ) u_fsm (
      .clk        (clk),
      .rst        (rst),
      .psel       (psel),
      .penable    (penable),
      .pwrite     (pwrite),
      .paddr      (paddr),
      .pwdata     (pwdata),
      .pstrb      (pstrb),
      .pready_o   (rdy),
      .commit_o   (commit),
      .req_write_o(req_write),
      .req_addr_o (req_addr),
      .req_wdata_o(req_wdata),
      .req_strb_o (req_strb)
   );

   // Decode and read mux work on the latched request, so the response is
   // purely a function of registered state.
   always_comb begin
      cfg_hit = '0;
      for (int i = 0; i < NUM_CFG; i++) begin
         cfg_hit[i] = (req_addr == A_CFG0 + ADDR_WIDTH'(4 * i));
      end
      is_ctrl   = (req_addr == A_CTRL);
      is_status = (req_addr == A_STATUS);
      is_id     = (req_addr == A_ID);
      aligned   = (req_addr[1:0] == 2'b00);
      start_req = req_write && is_ctrl && req_wdata[CTRL_START_BIT];
      // A rejected START also blocks IRQ_EN in the same write
      err = !aligned
         || !(is_ctrl || is_status || is_id || (|cfg_hit))
         || (req_write && busy_q && ((|cfg_hit) || start_req));

      rdata = '0;
      if (is_ctrl) rdata[CTRL_IRQ_EN_BIT] = irq_en_q;
      if (is_status) begin
         rdata[STATUS_BUSY_BIT] = busy_q;
         rdata[STATUS_DONE_BIT] = done_q;
      end
      if (is_id) rdata = DATA_WIDTH'(MVU_CSR_ID);
      for (int i = 0; i < NUM_CFG; i++) begin
         if (cfg_hit[i]) rdata = cfg_q[i];
      end
   end

   always_comb begin
      irq_en_d = irq_en_q;
      busy_d   = busy_q;
      done_d   = done_q;
      start_d  = 1'b0;
      cfg_d    = cfg_q;
      wr_ok    = commit && req_write && !err;

      if (wr_ok && is_ctrl) begin
         irq_en_d = req_wdata[CTRL_IRQ_EN_BIT];
         start_d  = req_wdata[CTRL_START_BIT];
      end
      if (wr_ok && is_status && req_wdata[STATUS_DONE_BIT]) done_d = 1'b0;
      if (wr_ok) begin
         for (int i = 0; i < NUM_CFG; i++) begin
            for (int b = 0; b < DATA_WIDTH / 8; b++) begin
               if (cfg_hit[i] && req_strb[b]) cfg_d[i][8*b +: 8] = req_wdata[8*b +: 8];
            end
         end
      end
      // Completion overrides a same-cycle W1C; a stray done while idle still sets DONE
      if (done_i) begin
         busy_d = 1'b0;
         done_d = 1'b1;
      end
      if (start_d) busy_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         irq_en_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         start_q  <= 1'b0;
         for (int i = 0; i < NUM_CFG; i++) cfg_q[i] <= '0;
      end else begin
         irq_en_q <= irq_en_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         start_q  <= start_d;
         cfg_q    <= cfg_d;
      end
   end

   always_comb begin
      cfg_o = '0;
      for (int i = 0; i < NUM_CFG; i++) cfg_o[DATA_WIDTH*i +: DATA_WIDTH] = cfg_q[i];
   end

   assign pready  = rdy;
   assign pslverr = rdy && err;
   assign prdata  = (rdy && !err && !req_write) ? rdata : '0;
   assign start_o = start_q;
   assign irq_o   = done_q && irq_en_q;

endmodule

// File: tb/tb_mvu_apb_csr.sv
// tb/tb_mvu_apb_csr.sv - self-checking bench for mvu_apb_csr
module tb_mvu_apb_csr;

   localparam int          NUM_CFG = 4;
   localparam int          WAIT    = 1;
   localparam logic [31:0] ID      = 32'h4D56_5501;

   logic                   clk, rst, psel, penable, pwrite, pready, pslverr, start_o, done_i, irq_o;
   logic [11:0]            paddr;
   logic [31:0]            pwdata, prdata;
   logic [3:0]             pstrb;
   logic [32*NUM_CFG-1:0]  cfg_o;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   logic [31:0] m_cfg [NUM_CFG];
   bit          m_irq_en, m_busy, m_done;

   typedef struct packed {
      logic        wr;
      logic [11:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic [31:0] exp_rd;
      logic        exp_err;
      logic        exp_start;
      logic        exp_irq;
      logic [31:0] exp_cfg0;
   } vec_t;

   vec_t vecs[$];

   mvu_apb_csr #(
      .ADDR_WIDTH (12),
      .DATA_WIDTH (32),
      .NUM_CFG    (NUM_CFG),
      .WAIT_CYCLES(WAIT)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .psel   (psel),
      .penable(penable),
      .pwrite (pwrite),
      .paddr  (paddr),
      .pwdata (pwdata),
      .pstrb  (pstrb),
      .pready (pready),
      .prdata (prdata),
      .pslverr(pslverr),
      .cfg_o  (cfg_o),
      .start_o(start_o),
      .done_i (done_i),
      .irq_o  (irq_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   // Called on a falling edge; returns on the falling edge after the completing edge.
   task automatic apb(input bit wr, input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                      input bit dn, output logic [31:0] rd, output logic err, output int waits);
      waits   = 0;
      psel    = 1'b1;
      penable = 1'b0;
      pwrite  = wr;
      paddr   = a;
      pwdata  = d;
      pstrb   = s;
      @(negedge clk);
      penable = 1'b1;
      while (pready !== 1'b1 && waits < 40) begin
         check("prdata_while_wait", prdata, 32'h0);
         check("pslverr_while_wait", pslverr, 1'b0);
         waits++;
         @(negedge clk);
      end
      check("pready_seen", pready, 1'b1);
      rd  = prdata;
      err = pslverr;
      if (dn) done_i = 1'b1;
      @(negedge clk);
      psel    = 1'b0;
      penable = 1'b0;
      done_i  = 1'b0;
   endtask

   // Register-map behaviour from the access rules, applied to the model state.
   task automatic model_xfer(input bit wr, input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [31:0] rd, output bit err, output bit st);
      int unsigned off;
      int k;
      off = a;
      rd  = 32'h0;
      err = 1'b0;
      st  = 1'b0;
      if (off % 4 != 0) begin
         err = 1'b1;
      end else if (off == 0) begin
         if (!wr) rd = m_irq_en ? 32'h2 : 32'h0;
         else if (d[0] && m_busy) err = 1'b1;
         else begin
            m_irq_en = d[1];
            if (d[0]) begin
               m_busy = 1'b1;
               st     = 1'b1;
            end
         end
      end else if (off == 4) begin
         if (!wr) rd = 32'(m_done) * 2 + 32'(m_busy);
         else if (d[1]) m_done = 1'b0;
      end else if (off == 60) begin
         if (!wr) rd = ID;
      end else if (off >= 8 && off < 8 + 4 * NUM_CFG) begin
         k = int'((off - 8) / 4);
         if (!wr) rd = m_cfg[k];
         else if (m_busy) err = 1'b1;
         else begin
            for (int b = 0; b < 4; b++) if (s[b]) m_cfg[k][8*b +: 8] = d[8*b +: 8];
         end
      end else begin
         err = 1'b1;
      end
   endtask

   initial begin
      logic [31:0] rd, erd;
      logic        err;
      int          waits;
      bit          eerr, est, wr;
      logic [11:0] a;
      logic [31:0] d;
      logic [3:0]  s;

      rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = '0; pwdata = '0; pstrb = '0; done_i = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      check("rst_pready", pready, 1'b0);
      check("rst_prdata", prdata, 32'h0);
      check("rst_pslverr", pslverr, 1'b0);
      check("rst_start_o", start_o, 1'b0);
      check("rst_irq_o", irq_o, 1'b0);
      for (int i = 0; i < NUM_CFG; i++) check($sformatf("rst_cfg%0d", i), cfg_o[32*i +: 32], 32'h0);

      //                wr    addr     wdata         strb   exp_rd        err   start irq   cfg0
      vecs.push_back('{1'b0, 12'h03C, 32'h0,        4'hF, ID,           1'b0, 1'b0, 1'b0, 32'h0});
      vecs.push_back('{1'b1, 12'h008, 32'hDEADBEEF, 4'h5, 32'h0,        1'b0, 1'b0, 1'b0, 32'h00AD00EF});
      vecs.push_back('{1'b0, 12'h008, 32'h0,        4'hF, 32'h00AD00EF, 1'b0, 1'b0, 1'b0, 32'h00AD00EF});
      vecs.push_back('{1'b1, 12'h000, 32'h3,        4'hF, 32'h0,        1'b0, 1'b1, 1'b0, 32'h00AD00EF});
      vecs.push_back('{1'b0, 12'h004, 32'h0,        4'hF, 32'h1,        1'b0, 1'b0, 1'b0, 32'h00AD00EF});
      vecs.push_back('{1'b1, 12'h00C, 32'h12345678, 4'hF, 32'h0,        1'b1, 1'b0, 1'b0, 32'h00AD00EF});
      vecs.push_back('{1'b0, 12'h00C, 32'h0,        4'hF, 32'h0,        1'b0, 1'b0, 1'b0, 32'h00AD00EF});
      vecs.push_back('{1'b1, 12'h000, 32'h1,        4'hF, 32'h0,        1'b1, 1'b0, 1'b0, 32'h00AD00EF});
      vecs.push_back('{1'b0, 12'h000, 32'h0,        4'hF, 32'h2,        1'b0, 1'b0, 1'b0, 32'h00AD00EF});
      vecs.push_back('{1'b0, 12'h020, 32'h0,        4'hF, 32'h0,        1'b1, 1'b0, 1'b0, 32'h00AD00EF});
      vecs.push_back('{1'b0, 12'h006, 32'h0,        4'hF, 32'h0,        1'b1, 1'b0, 1'b0, 32'h00AD00EF});
      vecs.push_back('{1'b1, 12'h03C, 32'h0,        4'hF, 32'h0,        1'b0, 1'b0, 1'b0, 32'h00AD00EF});
      vecs.push_back('{1'b1, 12'h004, 32'h1,        4'hF, 32'h0,        1'b0, 1'b0, 1'b0, 32'h00AD00EF});
      vecs.push_back('{1'b0, 12'h004, 32'h0,        4'hF, 32'h1,        1'b0, 1'b0, 1'b0, 32'h00AD00EF});
      vecs.push_back('{1'b1, 12'h008, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1, 1'b0, 1'b0, 32'h00AD00EF});
      vecs.push_back('{1'b0, 12'h03C, 32'h0,        4'hF, ID,           1'b0, 1'b0, 1'b0, 32'h00AD00EF});

      for (int k = 0; k < vecs.size(); k++) begin
         apb(vecs[k].wr, vecs[k].addr, vecs[k].wdata, vecs[k].strb, 1'b0, rd, err, waits);
         check($sformatf("vec%0d_prdata", k), rd, vecs[k].exp_rd);
         check($sformatf("vec%0d_pslverr", k), err, vecs[k].exp_err);
         check($sformatf("vec%0d_waits", k), waits, WAIT);
         check($sformatf("vec%0d_start_o", k), start_o, vecs[k].exp_start);
         check($sformatf("vec%0d_irq_o", k), irq_o, vecs[k].exp_irq);
         check($sformatf("vec%0d_cfg0", k), cfg_o[31:0], vecs[k].exp_cfg0);
         @(negedge clk);
         check($sformatf("vec%0d_start_o_drop", k), start_o, 1'b0);
      end

      // Job completion, then a DONE clear racing another completion
      done_i = 1'b1;
      @(negedge clk);
      done_i = 1'b0;
      check("irq_after_done", irq_o, 1'b1);
      apb(1'b0, 12'h004, 32'h0, 4'hF, 1'b0, rd, err, waits);
      check("status_done", rd, 32'h2);
      apb(1'b1, 12'h004, 32'h2, 4'hF, 1'b1, rd, err, waits);
      check("w1c_race_err", err, 1'b0);
      check("irq_set_wins", irq_o, 1'b1);
      apb(1'b0, 12'h004, 32'h0, 4'hF, 1'b0, rd, err, waits);
      check("status_set_wins", rd, 32'h2);
      apb(1'b1, 12'h004, 32'h2, 4'hF, 1'b0, rd, err, waits);
      check("irq_cleared", irq_o, 1'b0);
      apb(1'b0, 12'h004, 32'h0, 4'hF, 1'b0, rd, err, waits);
      check("status_cleared", rd, 32'h0);

      // Reset asserted during the access phase of a CFG write
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h010; pwdata = 32'hAAAA5555; pstrb = 4'hF;
      @(negedge clk);
      penable = 1'b1;
      rst     = 1'b1;
      @(negedge clk);
      check("midrst_pready", pready, 1'b0);
      check("midrst_prdata", prdata, 32'h0);
      check("midrst_pslverr", pslverr, 1'b0);
      check("midrst_start_o", start_o, 1'b0);
      check("midrst_irq_o", irq_o, 1'b0);
      for (int i = 0; i < NUM_CFG; i++) check($sformatf("midrst_cfg%0d", i), cfg_o[32*i +: 32], 32'h0);
      rst = 1'b0; psel = 1'b0; penable = 1'b0;
      @(negedge clk);
      apb(1'b0, 12'h010, 32'h0, 4'hF, 1'b0, rd, err, waits);
      check("post_rst_read", rd, 32'h0);
      check("post_rst_err", err, 1'b0);
      check("post_rst_waits", waits, WAIT);

      // Randomized traffic against the model, starting from reset state
      for (int i = 0; i < NUM_CFG; i++) m_cfg[i] = 32'h0;
      m_irq_en = 1'b0; m_busy = 1'b0; m_done = 1'b0;
      for (int t = 0; t < 300; t++) begin
         if ($urandom_range(0, 3) == 0) begin
            done_i = 1'b1;
            @(negedge clk);
            done_i = 1'b0;
            m_busy = 1'b0;
            m_done = 1'b1;
            check($sformatf("rnd%0d_irq_done", t), irq_o, m_done & m_irq_en);
         end
         wr = 1'($urandom_range(0, 1));
         a  = 12'($urandom_range(0, 63));
         if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
         d  = $urandom;
         s  = 4'($urandom_range(0, 15));
         model_xfer(wr, a, d, s, erd, eerr, est);
         apb(wr, a, d, s, 1'b0, rd, err, waits);
         check($sformatf("rnd%0d_prdata@%h", t, a), rd, erd);
         check($sformatf("rnd%0d_pslverr@%h", t, a), err, eerr);
         check($sformatf("rnd%0d_waits", t), waits, WAIT);
         check($sformatf("rnd%0d_start_o", t), start_o, est);
         check($sformatf("rnd%0d_irq_o", t), irq_o, m_done & m_irq_en);
         for (int i = 0; i < NUM_CFG; i++) check($sformatf("rnd%0d_cfg%0d", t, i), cfg_o[32*i +: 32], m_cfg[i]);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
